w_ptr_full: RTL and testbench

Write-domain pointer and full-flag generator for the asynchronous FIFO. It consumes the two-flop-synchronized Gray read pointer in the w_clk domain. It owns the binary and Gray write pointers, the RAM write address and write enable, and the full, almost-full, level and overflow status. Its Gray write pointer output feeds the write-to-read synchronizer.

---
 rtl/w_ptr_full.sv | 79 +++++++
 tb/tb_w_ptr_full.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/w_ptr_full.sv
// Write-domain pointer and full-flag generator for the asynchronous FIFO.
// Owns the binary/Gray write pointers and the full, almost-full, level and overflow status.
module w_ptr_full #(
  parameter int unsigned ADDR_BITS    = 4,
  parameter int unsigned AFULL_MARGIN = 2
) (
  input  logic                 w_clk,
  input  logic                 w_rst,
  input  logic                 w_inc,
  input  logic [ADDR_BITS:0]   w_sync_r_ptr,
  input  logic                 w_ovf_clr,
  output logic                 w_en,
  output logic [ADDR_BITS-1:0] w_addr,
  output logic [ADDR_BITS:0]   w_ptr,
  output logic                 w_full,
  output logic                 w_almost_full,
  output logic [ADDR_BITS:0]   w_level,
  output logic                 w_overflow
);

  localparam int unsigned         PW        = ADDR_BITS + 1;
  localparam int unsigned         DEPTH     = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0]  AFULL_LVL = PW'(DEPTH - AFULL_MARGIN);

  logic [ADDR_BITS:0] w_bin_q,   w_bin_d;
  logic [ADDR_BITS:0] w_gray_q,  w_gray_d;
  logic [ADDR_BITS:0] w_level_q, w_level_d;
  logic               w_full_q,  w_full_d;
  logic               w_afull_q, w_afull_d;
  logic               w_ovf_q,   w_ovf_d;
  logic [ADDR_BITS:0] r_bin;

  assign w_en = w_inc & ~w_full_q;

  // Gray-to-binary: each bit is the XOR of the Gray bits from the MSB down to it.
  always_comb begin
    r_bin = '0;
    for (int unsigned i = 0; i <= ADDR_BITS; i++) begin
      r_bin[i] = ^(w_sync_r_ptr >> i);
    end
  end

  always_comb begin
    w_bin_d   = w_bin_q + {{ADDR_BITS{1'b0}}, w_en};
    w_gray_d  = w_bin_d ^ (w_bin_d >> 1);
    w_full_d  = (w_gray_d == {~w_sync_r_ptr[ADDR_BITS -: 2],
                              w_sync_r_ptr[ADDR_BITS-2:0]});
    w_level_d = w_bin_d - r_bin;
    w_afull_d = (w_level_d >= AFULL_LVL);
    // Set has priority over a coincident clear.
    w_ovf_d   = (w_inc & w_full_q) | (w_ovf_q & ~w_ovf_clr);
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      w_bin_q   <= '0;
      w_gray_q  <= '0;
      w_level_q <= '0;
      w_full_q  <= 1'b0;
      w_afull_q <= 1'b0;
      w_ovf_q   <= 1'b0;
    end else begin
      w_bin_q   <= w_bin_d;
      w_gray_q  <= w_gray_d;
      w_level_q <= w_level_d;
      w_full_q  <= w_full_d;
      w_afull_q <= w_afull_d;
      w_ovf_q   <= w_ovf_d;
    end
  end

  assign w_addr        = w_bin_q[ADDR_BITS-1:0];
  assign w_ptr         = w_gray_q;
  assign w_full        = w_full_q;
  assign w_almost_full = w_afull_q;
  assign w_level       = w_level_q;
  assign w_overflow    = w_ovf_q;

endmodule

// File: tb/tb_w_ptr_full.sv
// Scoreboard bench for w_ptr_full: a count-based model predicts outputs per cycle.
module tb_w_ptr_full;

  localparam int unsigned A = 4;

  logic       w_clk = 1'b0;
  logic       w_rst;
  logic       w_inc;
  logic [A:0] w_sync_r_ptr;
  logic       w_ovf_clr;
  logic       w_en;
  logic [A-1:0] w_addr;
  logic [A:0] w_ptr;
  logic       w_full;
  logic       w_almost_full;
  logic [A:0] w_level;
  logic       w_overflow;

  w_ptr_full #(.ADDR_BITS(A), .AFULL_MARGIN(2)) dut (
    .w_clk(w_clk), .w_rst(w_rst), .w_inc(w_inc), .w_sync_r_ptr(w_sync_r_ptr),
    .w_ovf_clr(w_ovf_clr), .w_en(w_en), .w_addr(w_addr), .w_ptr(w_ptr),
    .w_full(w_full), .w_almost_full(w_almost_full), .w_level(w_level),
    .w_overflow(w_overflow)
  );

  always #5 w_clk = ~w_clk;

  typedef struct {
    logic [A:0]   ptr;
    logic [A-1:0] addr;
    logic         full;
    logic         afull;
    logic [A:0]   level;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [A:0] m_wcnt, m_rcnt, m_lvl;
  logic       m_full, m_afull, m_ovf;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [A:0] gray(input logic [A:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_wcnt = '0; m_rcnt = '0; m_lvl = '0;
    m_full = 1'b0; m_afull = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_ptr"},   32'(w_ptr),         32'd0);
    check({tag, "_addr"},  32'(w_addr),        32'd0);
    check({tag, "_full"},  32'(w_full),        32'd0);
    check({tag, "_afull"}, 32'(w_almost_full), 32'd0);
    check({tag, "_level"}, 32'(w_level),       32'd0);
    check({tag, "_ovf"},   32'(w_overflow),    32'd0);
    check({tag, "_en"},    32'(w_en),          32'd0);
  endtask

  // One cycle: entered just after a negedge, leaves just after the next negedge.
  task automatic step(input logic inc, input logic clr);
    exp_t e;
    logic acc;
    w_inc = inc; w_ovf_clr = clr; w_sync_r_ptr = gray(m_rcnt);
    #1;
    acc = inc & ~m_full;
    check("w_en", 32'(w_en), 32'(acc));
    if (acc) m_wcnt = m_wcnt + 1'b1;
    m_ovf   = (inc & m_full) | (m_ovf & ~clr);
    m_lvl   = m_wcnt - m_rcnt;
    m_full  = (m_lvl == 5'd16);
    m_afull = (m_lvl >= 5'd14);
    e.ptr = gray(m_wcnt); e.addr = m_wcnt[A-1:0]; e.full = m_full;
    e.afull = m_afull; e.level = m_lvl; e.ovf = m_ovf;
    sb.push_back(e);
    @(posedge w_clk); #1;
    check("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("ptr",   32'(w_ptr),         32'(e.ptr));
      check("addr",  32'(w_addr),        32'(e.addr));
      check("full",  32'(w_full),        32'(e.full));
      check("afull", 32'(w_almost_full), 32'(e.afull));
      check("level", 32'(w_level),       32'(e.level));
      check("ovf",   32'(w_overflow),    32'(e.ovf));
    end
    @(negedge w_clk);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset(input string tag);
    w_inc = 1'b0; w_ovf_clr = 1'b0;
    #2 w_rst = 1'b1;
    #1 chk_zero(tag);
    @(posedge w_clk); #1 chk_zero({tag, "_hold"});
    @(negedge w_clk);
    w_rst = 1'b0;
    model_reset();
    w_sync_r_ptr = '0;
  endtask

  always @(negedge w_clk) begin
    check("inv_full_level", 32'(w_level == 5'd16), 32'(w_full));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [A:0] hist[$];
    w_rst = 1'b1; w_inc = 1'b0; w_ovf_clr = 1'b0; w_sync_r_ptr = '0;
    model_reset();
    repeat (2) @(negedge w_clk);
    chk_zero("rst");
    w_rst = 1'b0;

    repeat (5) step(1'b1, 1'b0);
    pulse_reset("arst");
    step(1'b0, 1'b0);

    for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
    check("fill_ptr", 32'(w_ptr), 32'h18);

    repeat (3) step(1'b1, 1'b0);
    check("ovf_ptr_hold", 32'(w_ptr), 32'h18);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("ovf_set_wins", 32'(w_overflow), 32'd1);

    m_rcnt = 5'd4;
    step(1'b0, 1'b0);
    check("drain_level", 32'(w_level), 32'd12);

    pulse_reset("rst2");
    for (int k = 0; k < 40; k++) begin
      m_rcnt = (hist.size() >= 3) ? hist[hist.size() - 3] : '0;
      step(1'b1, 1'b0);
      hist.push_back(m_wcnt);
      check("wrap_lvl_le3", 32'(w_level <= 5'd3), 32'd1);
      check("wrap_nofull",  32'(w_full),          32'd0);
    end

    pulse_reset("rst3");
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0);
    m_rcnt = 5'd1;
    step(1'b1, 1'b0);
    check("simul_level", 32'(w_level), 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
